sound_tone_player: RTL and testbench

- Consumer end of the game-event pulse stretcher: takes its stretched level windows (block-hit sound window, game-over window) and converts them into an audible square wave for the board buzzer pin.
- While the sound window is high, plays a fixed hit tone.
- On a game-over window rising edge, plays a fixed 4-note descending melody.
- Runs at 100 MHz (10 ns cycle).

---
 rtl/sound_tone_player.sv | 148 ++++++++++++++
 tb/tb_sound_tone_player.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_tone_player.sv
// Buzzer driver for the game-event windows: a square-wave hit tone while the
// sound window is high, and a 4-note descending melody on a game-over rising edge.
module sound_tone_player #(
  parameter int HIT_HALF    = 113_636,
  parameter int NOTE0_HALF  = 95_602,
  parameter int NOTE1_HALF  = 127_551,
  parameter int NOTE2_HALF  = 151_515,
  parameter int NOTE3_HALF  = 190_840,
  parameter int NOTE_CYCLES = 12_500_000,
  parameter int HP_BITS     = 18,
  parameter int NOTE_BITS   = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sound_window,
  input  logic       game_over_window,
  output logic       tone_out,
  output logic       busy,
  output logic       melody_active,
  output logic [1:0] note_index
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HIT    = 2'd1;
  localparam logic [1:0] S_MELODY = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [HP_BITS-1:0]   HIT_LIM   = HP_BITS'(HIT_HALF - 1);
  localparam logic [HP_BITS-1:0]   NOTE0_LIM = HP_BITS'(NOTE0_HALF - 1);
  localparam logic [HP_BITS-1:0]   NOTE1_LIM = HP_BITS'(NOTE1_HALF - 1);
  localparam logic [HP_BITS-1:0]   NOTE2_LIM = HP_BITS'(NOTE2_HALF - 1);
  localparam logic [HP_BITS-1:0]   NOTE3_LIM = HP_BITS'(NOTE3_HALF - 1);
  localparam logic [NOTE_BITS-1:0] NOTE_LIM  = NOTE_BITS'(NOTE_CYCLES - 1);

  logic [1:0]           state_q, state_d;
  logic                 tone_q, tone_d;
  logic [HP_BITS-1:0]   hp_q, hp_d;
  logic [NOTE_BITS-1:0] nc_q, nc_d;
  logic [1:0]           note_q, note_d;
  logic                 go_prev_q;
  logic                 busy_q, mel_q;
  logic                 go_rise;
  logic [HP_BITS-1:0]   melody_lim;

  assign go_rise = game_over_window & ~go_prev_q;

  always_comb begin
    case (note_q)
      2'd0:    melody_lim = NOTE0_LIM;
      2'd1:    melody_lim = NOTE1_LIM;
      2'd2:    melody_lim = NOTE2_LIM;
      default: melody_lim = NOTE3_LIM;
    endcase
  end

  always_comb begin
    state_d = state_q;
    tone_d  = tone_q;
    hp_d    = hp_q;
    nc_d    = nc_q;
    note_d  = note_q;
    case (state_q)
      S_IDLE: begin
        tone_d = 1'b0;
        hp_d   = '0;
        nc_d   = '0;
        note_d = 2'd0;
        // Game-over takes priority over a simultaneous hit
        if (go_rise)           state_d = S_MELODY;
        else if (sound_window) state_d = S_HIT;
      end
      S_HIT: begin
        if (go_rise) begin
          state_d = S_MELODY;
          tone_d  = 1'b0;
          hp_d    = '0;
          nc_d    = '0;
          note_d  = 2'd0;
        end else if (!sound_window) begin
          state_d = S_IDLE;
          tone_d  = 1'b0;
          hp_d    = '0;
        end else if (hp_q == HIT_LIM) begin
          hp_d   = '0;
          tone_d = ~tone_q;
        end else begin
          hp_d = hp_q + HP_BITS'(1);
        end
      end
      S_MELODY: begin
        // Every note starts silent with a fresh half-period
        if (nc_q == NOTE_LIM) begin
          nc_d   = '0;
          hp_d   = '0;
          tone_d = 1'b0;
          if (note_q == 2'd3) begin
            state_d = S_DONE;
            note_d  = 2'd0;
          end else begin
            note_d = note_q + 2'd1;
          end
        end else begin
          nc_d = nc_q + NOTE_BITS'(1);
          if (hp_q == melody_lim) begin
            hp_d   = '0;
            tone_d = ~tone_q;
          end else begin
            hp_d = hp_q + HP_BITS'(1);
          end
        end
      end
      S_DONE: begin
        tone_d = 1'b0;
        if (!game_over_window) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // go_prev resets high so a window already high at reset release is not an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tone_q    <= 1'b0;
      hp_q      <= '0;
      nc_q      <= '0;
      note_q    <= 2'd0;
      go_prev_q <= 1'b1;
      busy_q    <= 1'b0;
      mel_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tone_q    <= tone_d;
      hp_q      <= hp_d;
      nc_q      <= nc_d;
      note_q    <= note_d;
      go_prev_q <= game_over_window;
      busy_q    <= (state_d != S_IDLE);
      mel_q     <= (state_d == S_MELODY);
    end
  end

  assign tone_out      = tone_q;
  assign busy          = busy_q;
  assign melody_active = mel_q;
  assign note_index    = note_q;

endmodule

// File: tb/tb_sound_tone_player.sv
// Bench for sound_tone_player: directed scenarios plus random traffic, all
// checked against a cycle-count model of the tone/melody rules.
module tb_sound_tone_player;

  localparam int HIT_HALF = 4;
  localparam int NC       = 20;
  localparam int NH0 = 2, NH1 = 3, NH2 = 4, NH3 = 5;

  localparam int M_IDLE = 0, M_HIT = 1, M_MEL = 2, M_DONE = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sound_window = 1'b0;
  logic       game_over_window = 1'b0;
  logic       tone_out, busy, melody_active;
  logic [1:0] note_index;

  int n_tests = 0;
  int n_fail  = 0;

  sound_tone_player #(
    .HIT_HALF(HIT_HALF), .NOTE0_HALF(NH0), .NOTE1_HALF(NH1),
    .NOTE2_HALF(NH2), .NOTE3_HALF(NH3), .NOTE_CYCLES(NC),
    .HP_BITS(18), .NOTE_BITS(24)
  ) dut (
    .clk(clk), .reset(reset), .sound_window(sound_window),
    .game_over_window(game_over_window), .tone_out(tone_out), .busy(busy),
    .melody_active(melody_active), .note_index(note_index)
  );

  always #5 clk = ~clk;

  // Model: mode plus cycles elapsed since entering it; tone derived arithmetically
  int m_mode = M_IDLE;
  int m_t = 0;
  bit m_go_prev = 1'b1;

  always @(posedge clk) begin
    bit rise;
    rise = game_over_window && !m_go_prev;
    if (reset) begin
      m_mode = M_IDLE; m_t = 0; m_go_prev = 1'b1;
    end else begin
      case (m_mode)
        M_IDLE: if (rise) begin m_mode = M_MEL; m_t = 0; end
                else if (sound_window) begin m_mode = M_HIT; m_t = 0; end
        M_HIT:  if (rise) begin m_mode = M_MEL; m_t = 0; end
                else if (!sound_window) m_mode = M_IDLE;
                else m_t++;
        M_MEL:  begin m_t++; if (m_t == 4 * NC) m_mode = M_DONE; end
        default: if (!game_over_window) m_mode = M_IDLE;
      endcase
      m_go_prev = game_over_window;
    end
  end

  function automatic logic [4:0] model_v();
    int half[4];
    int note, k;
    logic tn;
    half = '{NH0, NH1, NH2, NH3};
    case (m_mode)
      M_HIT: return {((m_t / HIT_HALF) % 2 == 1), 1'b1, 1'b0, 2'd0};
      M_MEL: begin
        note = m_t / NC;
        k    = m_t % NC;
        tn   = ((k / half[note]) % 2 == 1);
        return {tn, 1'b1, 1'b1, 2'(note)};
      end
      M_DONE:  return 5'b01000;
      default: return 5'b00000;
    endcase
  endfunction

  wire [4:0] dut_v = {tone_out, busy, melody_active, note_index};

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; sound_window = 1'b0; game_over_window = 1'b0;
    repeat (3) cyc();
    n_tests++;
    if (dut_v !== 5'b00000) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 00000", dut_v);
    end
    reset = 1'b0;
    cyc();
    n_tests++;
    if (dut_v !== model_v()) begin
      n_fail++; $display("FAIL reset_idle: got %b want %b", dut_v, model_v());
    end
  endtask

  task automatic test_hit();
    int first_hi = -1;
    sound_window = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      if (tone_out && first_hi < 0) first_hi = i;
      n_tests++;
      if (dut_v !== model_v()) begin
        n_fail++; $display("FAIL hit_cycle%0d: got %b want %b", i, dut_v, model_v());
      end
      if (i == 1) begin
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL hit_busy: got %b want 1", busy); end
      end
    end
    n_tests++;
    if (first_hi != HIT_HALF + 1) begin
      n_fail++; $display("FAIL hit_first_toggle: got cycle %0d want %0d", first_hi, HIT_HALF + 1);
    end
    sound_window = 1'b0;
    cyc();
    n_tests++;
    if ({tone_out, busy} !== 2'b00) begin
      n_fail++; $display("FAIL hit_stop: got %b want 00", {tone_out, busy});
    end
  endtask

  task automatic test_melody();
    int mel_cycles = 0;
    game_over_window = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      cyc();
      if (melody_active) mel_cycles++;
      n_tests++;
      if (dut_v !== model_v()) begin
        n_fail++; $display("FAIL melody_cycle%0d: got %b want %b", i, dut_v, model_v());
      end
    end
    n_tests++;
    if (mel_cycles != 4 * NC) begin
      n_fail++; $display("FAIL melody_length: got %0d want %0d", mel_cycles, 4 * NC);
    end
    n_tests++;
    if (dut_v !== 5'b01000) begin
      n_fail++; $display("FAIL melody_done: got %b want 01000", dut_v);
    end
    game_over_window = 1'b0;
    cyc();
    n_tests++;
    if (dut_v !== 5'b00000) begin
      n_fail++; $display("FAIL melody_idle: got %b want 00000", dut_v);
    end
  endtask

  task automatic test_hit_to_melody();
    sound_window = 1'b1;
    repeat (5 + $urandom_range(0, 6)) cyc();
    game_over_window = 1'b1;
    cyc();
    n_tests++;
    if (dut_v !== 5'b01100) begin
      n_fail++; $display("FAIL hit_preempt: got %b want 01100", dut_v);
    end
    // Inputs wiggle throughout; the melody must ignore all of it
    for (int i = 0; i < 4 * NC + 5; i++) begin
      if (i >= NC && i < 2 * NC) begin
        sound_window     = 1'($urandom_range(0, 1));
        game_over_window = 1'b0;
      end else begin
        sound_window = 1'b0;
      end
      cyc();
      n_tests++;
      if (dut_v !== model_v()) begin
        n_fail++; $display("FAIL ignore_cycle%0d: got %b want %b", i, dut_v, model_v());
      end
    end
    n_tests++;
    if (dut_v !== 5'b00000) begin
      n_fail++; $display("FAIL ignore_end_idle: got %b want 00000", dut_v);
    end
  endtask

  task automatic test_go_through_reset();
    bit bad = 1'b0;
    game_over_window = 1'b1; sound_window = 1'b0; reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (melody_active || tone_out) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++; $display("FAIL held_window_no_melody: got melody/tone activity want none");
    end
    game_over_window = 1'b0;
    cyc();
    game_over_window = 1'b1;
    cyc();
    n_tests++;
    if (dut_v !== 5'b01100) begin
      n_fail++; $display("FAIL retrigger_melody: got %b want 01100", dut_v);
    end
  endtask

  task automatic test_reset_mid_melody();
    // Already in melody from previous task at t=0; advance to note 2, cycle 10
    repeat (2 * NC + 10) cyc();
    n_tests++;
    if (note_index !== 2'd2) begin
      n_fail++; $display("FAIL pre_reset_note: got %0d want 2", note_index);
    end
    reset = 1'b1;
    cyc();
    n_tests++;
    if (dut_v !== 5'b00000) begin
      n_fail++; $display("FAIL reset_mid: got %b want 00000", dut_v);
    end
    reset = 1'b0; game_over_window = 1'b0; sound_window = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      n_tests++;
      if (dut_v !== model_v()) begin
        n_fail++; $display("FAIL post_reset_hit%0d: got %b want %b", i, dut_v, model_v());
      end
    end
    sound_window = 1'b0;
    cyc();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      sound_window = ($urandom_range(0, 9) < 7) ? sound_window : ~sound_window;
      if ($urandom_range(0, 59) == 0) game_over_window = ~game_over_window;
      reset = ($urandom_range(0, 599) == 0);
      cyc();
      n_tests++;
      if (dut_v !== model_v()) begin
        n_fail++; $display("FAIL random_cycle%0d: got %b want %b", i, dut_v, model_v());
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_hit();
    test_melody();
    test_hit_to_melody();
    test_go_through_reset();
    test_reset_mid_melody();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
